aes_round_seq: RTL and testbench

Iterative AES round sequencer: accepts one 128-bit block per job over a valid/ready handshake and owns the 128-bit state register. It drives a shared external combinational round unit and an external round-key store for nr rounds (10/12/14), then presents the result on an output handshake. It sits between the host-side block interface and the existing SubBytes/ShiftRows/MixColumns/AddRoundKey and inverse datapath plus KeyExpansion output.

---
 rtl/aes_round_seq.sv | 157 +++++++++++++++
 tb/tb_aes_round_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_seq.sv
// aes_round_seq: iterative AES round sequencer driving an external round unit and key store.
// Optional `AES_SEQ_SELFCHECK_EN`: encrypt results are decrypted back and compared to the plaintext.
module aes_round_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    input  logic         mode,
    input  logic [1:0]   key_len,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output logic         busy,
    output logic         cfg_err,
    output logic         check_ok,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_i,
    output logic [127:0] rnd_state,
    output logic         rnd_dec,
    output logic         rnd_final,
    input  logic [127:0] rnd_result
);

`ifdef AES_SEQ_SELFCHECK_EN
    typedef enum logic [1:0] {IDLE, ROUND, DONE, CHKLD} fsm_t;
`else
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
`endif

    fsm_t         fsm_reg, fsm_next;
    logic [127:0] state_reg, state_next;
    logic [3:0]   r_reg, r_next;
    logic         dec_reg, dec_next;
    logic [3:0]   nr_reg, nr_next;
    logic [3:0]   nr_in;

`ifdef AES_SEQ_SELFCHECK_EN
    logic [127:0] plain_reg, plain_next;
    logic [127:0] cipher_reg, cipher_next;
    logic         chk_pass_reg, chk_pass_next;
`endif

    // Reserved key_len=3 runs as AES-128.
    assign nr_in     = (key_len == 2'd1) ? 4'd12 : (key_len == 2'd2) ? 4'd14 : 4'd10;
    assign rnd_state = state_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg      <= IDLE;
            state_reg    <= '0;
            r_reg        <= 4'd0;
            dec_reg      <= 1'b0;
            nr_reg       <= 4'd10;
`ifdef AES_SEQ_SELFCHECK_EN
            plain_reg    <= '0;
            cipher_reg   <= '0;
            chk_pass_reg <= 1'b0;
`endif
        end else begin
            fsm_reg      <= fsm_next;
            state_reg    <= state_next;
            r_reg        <= r_next;
            dec_reg      <= dec_next;
            nr_reg       <= nr_next;
`ifdef AES_SEQ_SELFCHECK_EN
            plain_reg    <= plain_next;
            cipher_reg   <= cipher_next;
            chk_pass_reg <= chk_pass_next;
`endif
        end
    end

    always_comb begin
        fsm_next      = fsm_reg;
        state_next    = state_reg;
        r_next        = r_reg;
        dec_next      = dec_reg;
        nr_next       = nr_reg;
`ifdef AES_SEQ_SELFCHECK_EN
        plain_next    = plain_reg;
        cipher_next   = cipher_reg;
        chk_pass_next = chk_pass_reg;
`endif
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b1;
        cfg_err       = 1'b0;
        check_ok      = 1'b0;
        dout          = state_reg;
        rk_idx        = 4'd0;
        rnd_dec       = 1'b0;
        rnd_final     = 1'b0;

        case (fsm_reg)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                rk_idx   = mode ? nr_in : 4'd0;
                if (in_valid) begin
                    cfg_err    = ~rst & (key_len == 2'd3);
                    state_next = din ^ rk_i;
                    dec_next   = mode;
                    nr_next    = nr_in;
                    r_next     = 4'd1;
                    fsm_next   = ROUND;
`ifdef AES_SEQ_SELFCHECK_EN
                    chk_pass_next = 1'b0;
                    if (!mode)
                        plain_next = din;
`endif
                end
            end
            ROUND: begin
                rk_idx     = dec_reg ? (nr_reg - r_reg) : r_reg;
                rnd_dec    = dec_reg;
                rnd_final  = (r_reg == nr_reg);
                state_next = rnd_result;
                // r holds on the final round so it never passes 14.
                if (r_reg == nr_reg) begin
`ifdef AES_SEQ_SELFCHECK_EN
                    fsm_next = dec_reg ? DONE : CHKLD;
`else
                    fsm_next = DONE;
`endif
                end else begin
                    r_next = r_reg + 4'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
`ifdef AES_SEQ_SELFCHECK_EN
                if (chk_pass_reg) begin
                    dout     = cipher_reg;
                    check_ok = (state_reg == plain_reg);
                end
`endif
                if (out_ready)
                    fsm_next = IDLE;
            end
`ifdef AES_SEQ_SELFCHECK_EN
            CHKLD: begin
                // Start the inverse pass from the ciphertext with the last round key.
                rk_idx        = nr_reg;
                cipher_next   = state_reg;
                state_next    = state_reg ^ rk_i;
                dec_next      = 1'b1;
                r_next        = 4'd1;
                chk_pass_next = 1'b1;
                fsm_next      = ROUND;
            end
`endif
            default: fsm_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq: behavioural AES round unit and key store around the sequencer,
// FIPS-197 vectors checked through a scoreboard queue.
module tb_aes_round_seq;
    typedef logic [7:0] byte_t;
    typedef struct {
        logic [127:0] dout;
        logic         chk;
        int           lat;
    } exp_t;

`ifdef AES_SEQ_SELFCHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, mode, out_valid, out_ready;
    logic         busy, cfg_err, check_ok, rnd_dec, rnd_final;
    logic [1:0]   key_len;
    logic [3:0]   rk_idx;
    logic [127:0] din, dout, rk_i, rnd_state, rnd_result;
    logic         corrupt;

    byte_t        sbox [256];
    byte_t        isbox [256];
    logic [127:0] rk_tab [16];
    exp_t         sb [$];
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    aes_round_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .mode(mode), .key_len(key_len), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .busy(busy), .cfg_err(cfg_err), .check_ok(check_ok),
        .rk_idx(rk_idx), .rk_i(rk_i), .rnd_state(rnd_state), .rnd_dec(rnd_dec),
        .rnd_final(rnd_final), .rnd_result(rnd_result)
    );

    function automatic byte_t xt(byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gmul(byte_t a, byte_t b);
        byte_t p = 8'h00;
        byte_t x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic byte_t rotl(byte_t x, int n);
        return byte_t'((x << n) | (x >> (8 - n)));
    endfunction

    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            byte_t inv = 8'h00;
            byte_t s;
            for (int y = 1; y < 256; y++)
                if (gmul(byte_t'(v), byte_t'(y)) == 8'h01) inv = byte_t'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox[v] = s;
            isbox[s] = byte_t'(v);
        end
    endtask

    function automatic logic [31:0] subw(logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic load_key(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        byte_t rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 60; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk == 8 && i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k < 15; k++) rk_tab[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        rk_tab[15] = '0;
    endtask

    // Straightforward FIPS-197 Cipher / InvCipher round; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] aes_round(logic [127:0] s, logic [127:0] k, logic dec, logic fin);
        byte_t a [16];
        byte_t b [16];
        byte_t cf [4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c+r] = dec ? isbox[a[4*((c-r+4)%4)+r]] : sbox[a[4*((c+r)%4)+r]];
        if (dec)
            for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[127-8*i -: 8];
        if (!fin) begin
            if (dec) cf = '{8'd14, 8'd11, 8'd13, 8'd9};
            else     cf = '{8'd2, 8'd3, 8'd1, 8'd1};
            for (int c = 0; c < 4; c++) begin
                byte_t n [4];
                for (int r = 0; r < 4; r++) begin
                    n[r] = 8'h00;
                    for (int j = 0; j < 4; j++) n[r] = n[r] ^ gmul(cf[(j-r+4)%4], b[4*c+j]);
                end
                for (int r = 0; r < 4; r++) b[4*c+r] = n[r];
            end
        end
        if (!dec)
            for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[127-8*i -: 8];
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o;
    endfunction

    assign rk_i       = rk_tab[rk_idx] ^ ((corrupt && rnd_dec) ? 128'h1 : 128'h0);
    assign rnd_result = aes_round(rnd_state, rk_i, rnd_dec, rnd_final);

    task automatic chk(input string tag, input string what, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    task automatic run_job(input string tag, input logic [127:0] d, input logic m, input logic [1:0] kl,
                           input logic [127:0] exp_d, input logic exp_chk, input int hold);
        int nr = (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
        bit enc_chk = SC && !m;
        int lat = enc_chk ? 2*nr + 2 : nr + 1;
        int k = 0;
        int seq_err = 0;
        int hold_err = 0;
        exp_t e;
        e.dout = exp_d; e.chk = exp_chk; e.lat = lat;
        sb.push_back(e);

        @(negedge clk);
        in_valid = 1'b1; din = d; mode = m; key_len = kl; out_ready = (hold == 0);
        #1;
        chk(tag, "in_ready", in_ready, 1);
        chk(tag, "cfg_err", cfg_err, (kl == 2'd3));
        chk(tag, "rk_idx0", rk_idx, m ? nr : 0);
        @(posedge clk); #1;
        in_valid = 1'b0; din = {$urandom, $urandom, $urandom, $urandom};
        chk(tag, "cfg_err_end", cfg_err, 0);

        while (k < 40) begin
            int ei, ej;
            bit ef, ed;
            @(negedge clk);
            k++;
            if (out_valid) break;
            if (enc_chk && k == nr + 1) begin
                ei = nr; ef = 0; ed = 0;
            end else if (enc_chk && k > nr + 1) begin
                ej = k - nr - 1; ei = nr - ej; ef = (ej == nr); ed = 1;
            end else begin
                ei = m ? nr - k : k; ef = (k == nr); ed = m;
            end
            if (rk_idx !== 4'(ei) || rnd_final !== ef || rnd_dec !== ed || in_ready !== 1'b0 || busy !== 1'b1)
                seq_err++;
        end
        chk(tag, "round_seq", seq_err, 0);

        e = sb.pop_front();
        chk(tag, "latency", k, e.lat);
        chk(tag, "dout", dout, e.dout);
        chk(tag, "check_ok", check_ok, e.chk);

        if (hold > 0) begin
            in_valid = 1'b1; din = {$urandom, $urandom, $urandom, $urandom};
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (out_valid !== 1'b1 || dout !== e.dout || in_ready !== 1'b0 || busy !== 1'b1)
                    hold_err++;
            end
            chk(tag, "hold", hold_err, 0);
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk(tag, "after_valid", out_valid, 0);
        chk(tag, "after_busy", busy, 0);
        chk(tag, "after_ready", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; din = '0; mode = 1'b0; key_len = 2'd0;
        out_ready = 1'b0; corrupt = 1'b0;
        build_sbox();
        load_key(K128, 4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", "out_valid", out_valid, 0);
        chk("reset", "busy", busy, 0);
        chk("reset", "check_ok", check_ok, 0);
        chk("reset", "in_ready", in_ready, 1);
        chk("reset", "state", rnd_state, 0);
        chk("reset", "rnd_ctl", {rnd_dec, rnd_final}, 0);
        in_valid = 1'b1; key_len = 2'd3; din = PT;
        #1;
        chk("reset", "cfg_err", cfg_err, 0);
        @(posedge clk); #1;
        chk("reset", "no_accept", busy, 0);
        in_valid = 1'b0; key_len = 2'd0;
        rst = 1'b0;

        run_job("enc128", PT, 1'b0, 2'd0, CT1, SC, 0);
        load_key(K256, 8);
        run_job("dec256", CT3, 1'b1, 2'd2, PT, 1'b0, 0);
        load_key(K192, 6);
        run_job("enc192", PT, 1'b0, 2'd1, CT2, SC, 0);
        load_key(K128, 4);
        run_job("backpr", PT, 1'b0, 2'd0, CT1, SC, 20);

        // Abort during round 5.
        @(negedge clk);
        in_valid = 1'b1; din = PT; mode = 1'b0; key_len = 2'd0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort", "out_valid", out_valid, 0);
        chk("abort", "busy", busy, 0);
        chk("abort", "in_ready", in_ready, 1);
        run_job("post_abort", PT, 1'b0, 2'd0, CT1, SC, 0);

        run_job("klen3", PT, 1'b0, 2'd3, CT1, SC, 0);
        run_job("dec128", CT1, 1'b1, 2'd0, PT, 1'b0, 0);
`ifdef AES_SEQ_SELFCHECK_EN
        corrupt = 1'b1;
        run_job("corrupt", PT, 1'b0, 2'd0, CT1, 1'b0, 0);
        corrupt = 1'b0;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
